mesh_print_monitor: RTL and testbench
=====================================

MESH_PRINT_MONITOR -- requirements
Module: mesh_print_monitor

Interface
REQ-001 SHALL have parameters: N_CHAN default 4, number of tile channels (1..16); ADDR_W default 32; DATA_W default 32; AW_DEPTH default 8, power of 2, outstanding-burst tracker depth; MON_BASE default 32'h2FFF_0000, window base; CHAN_STRIDE default 32'h10, per-channel window size.
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: aw_valid, aw_ready  in  1  snooped AW handshake; aw_addr  in  ADDR_W  burst address; aw_len  in  8  AXI burst length minus one.
REQ-004 SHALL have ports: w_valid, w_ready, w_last  in  1  snooped W handshake; w_data  in  DATA_W  beat data; w_strb  in  DATA_W/8  byte strobes.
REQ-005 SHALL have ports: char_valid  out  1  stdout byte pulse; err_valid  out  1  stderr byte pulse; eoc_valid  out  1  exit-code pulse; out_byte  out  8  stdout/stderr byte; eoc_code  out  32  exit code; out_chan  out  $clog2(N_CHAN) (min 1)  source channel.
REQ-006 SHALL have ports: eoc_done  out  N_CHAN  sticky per-channel exit seen; all_done  out  1  AND of eoc_done; overflow  out  1  sticky tracker overflow; orphan_w  out  1  sticky W beat with no AW tracked.

Function
REQ-007 An AW handshake (aw_valid&aw_ready) SHALL be decoded: in window iff MON_BASE <= aw_addr < MON_BASE+N_CHAN*CHAN_STRIDE; chan=(aw_addr-MON_BASE)/CHAN_STRIDE; kind by aw_addr[3:2]: 0 STDERR, 1 STDOUT, 2 EOC, 3 NONE; out-of-window kind NONE.
REQ-008 Every AW handshake SHALL push {kind, chan, aw_len} into the tracker FIFO, including kind NONE, so W beats align in AW order.
REQ-009 A W handshake SHALL consume the FIFO head: decrement head beat count; pop on w_last; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-010 Head kind STDOUT/STDERR: byte = w_data byte of lowest set w_strb bit; no strb set -> no output; char_valid/err_valid pulse exactly one cycle, registered, one cycle after the W handshake.
REQ-011 Head kind EOC: eoc_code = w_data[31:0], eoc_valid one-cycle pulse one cycle after handshake, eoc_done[chan] set and held; only the first EOC per channel pulses eoc_valid, later ones ignored.
REQ-012 Head kind NONE: beat consumed, no output.
REQ-013 FIFO full on AW handshake: entry not pushed, overflow set, skip counter (8 bit, saturating) incremented; while skip > 0 all further AWs SHALL increment skip instead of pushing.
REQ-014 W beat with FIFO empty and skip > 0: discarded, skip decremented on w_last.
REQ-015 W beat with FIFO empty and skip = 0 (W-before-AW): discarded, orphan_w set; no output.
REQ-016 At most one of char_valid, err_valid, eoc_valid SHALL be high in any cycle.
REQ-017 Block SHALL be a passive monitor: no output drives the AXI bus; ready inputs never generated.

Reset
REQ-018 rst_n high SHALL asynchronously clear FIFO, skip counter, all pulses, eoc_done, overflow, orphan_w; all outputs read 0 during and after reset.
REQ-019 Reset mid-burst SHALL discard tracked bursts; beats after release of an AW seen before reset count as orphan_w.

Configuration
REQ-020 With MESH_PRINT_MON_DISPLAY_EN defined: stdout bytes SHALL be $write as characters; stderr bytes and exit codes $display'd with channel number; without it: no simulation output, hardware ports unchanged.

Structure
REQ-021 Package mesh_print_mon_pkg SHALL hold kind enum (STDERR, STDOUT, EOC, NONE), tracker entry typedef, register offsets 0x0/0x4/0x8.
REQ-022 Tracker SHALL be a fifo_v3 instance (common_cells), DEPTH=AW_DEPTH, dtype=entry typedef; decode, beat counting, skip logic in top module.

Verification
REQ-023 Single-beat AW 0x2FFF_0014, W data 0x41 strb 0001 -> char_valid 1 cycle later, out_byte 0x41, out_chan 1.
REQ-024 AW 0x2FFF_0008 (ch0 EOC), W 0x0000_0003 -> eoc_valid, eoc_code 3, eoc_done[0]=1; repeat EOC -> no pulse; EOC all 4 channels -> all_done=1.
REQ-025 Interleaved: AW to 0x1000_0000 len 3 then AW stdout ch2, 5 W beats -> only beat 5 produces char, out_chan 2.
REQ-026 9 AWs with no W (AW_DEPTH 8) -> overflow=1, skip=1; 9 single-beat W -> 8 tracked beats processed, 9th discarded, skip=0.
REQ-027 W beat with no AW -> orphan_w=1, no pulse; rst_n asserted mid-burst -> all outputs 0, FIFO empty.

Source files
------------

// File: rtl/mesh_print_mon_pkg.sv
// Shared types for the mesh print monitor: burst kinds, tracker entry, window offsets.
package mesh_print_mon_pkg;

  typedef enum logic [1:0] {
    KIND_STDERR = 2'd0,
    KIND_STDOUT = 2'd1,
    KIND_EOC    = 2'd2,
    KIND_NONE   = 2'd3
  } mon_kind_e;

  // Register offsets inside one channel's window.
  localparam logic [3:0] OFF_STDERR = 4'h0;
  localparam logic [3:0] OFF_STDOUT = 4'h4;
  localparam logic [3:0] OFF_EOC    = 4'h8;

  // One tracked AW burst; chan is wide enough for 16 channels.
  typedef struct packed {
    mon_kind_e   kind;
    logic [3:0]  chan;
    logic [7:0]  len;
  } trk_entry_t;

  function automatic mon_kind_e decode_kind(input logic [1:0] word_sel);
    mon_kind_e k;
    case ({word_sel, 2'b00})
      OFF_STDERR: k = KIND_STDERR;
      OFF_STDOUT: k = KIND_STDOUT;
      OFF_EOC:    k = KIND_EOC;
      default:    k = KIND_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 port naming (active-low async reset).
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
  logic                  mem_we;
  dtype                  mem_q [DEPTH];

  function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
    return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;
    data_o   = mem_q[rd_ptr_q];
    if (push_i && !full_o) begin
      mem_we   = 1'b1;
      wr_ptr_d = ptr_inc(wr_ptr_q);
      cnt_d    = cnt_q + 1'b1;
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d    = (push_i && !full_o) ? cnt_q : cnt_q - 1'b1;
    end
    // Fall-through: a word pushed into an empty FIFO and popped at once never lands.
    if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        mem_we   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
      end
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      mem_we   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mesh_print_monitor.sv
// Passive AXI AW/W snooper turning per-tile print/exit writes into byte and exit-code pulses.
// Define MESH_PRINT_MON_DISPLAY_EN to echo the decoded stream in simulation. rst_n is active-high.
module mesh_print_monitor
  import mesh_print_mon_pkg::*;
#(
  parameter int unsigned N_CHAN      = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned AW_DEPTH    = 8,
  parameter logic [31:0] MON_BASE    = 32'h2FFF_0000,
  parameter logic [31:0] CHAN_STRIDE = 32'h10,
  localparam int unsigned CHAN_W     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                aw_valid,
  input  logic                aw_ready,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [7:0]          aw_len,
  input  logic                w_valid,
  input  logic                w_ready,
  input  logic                w_last,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  output logic                char_valid,
  output logic                err_valid,
  output logic                eoc_valid,
  output logic [7:0]          out_byte,
  output logic [31:0]         eoc_code,
  output logic [CHAN_W-1:0]   out_chan,
  output logic [N_CHAN-1:0]   eoc_done,
  output logic                all_done,
  output logic                overflow,
  output logic                orphan_w
);

  localparam int unsigned       NBYTES   = DATA_W / 8;
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(MON_BASE);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(CHAN_STRIDE);

  // A handshake is valid&ready; the monitor only observes, never back-pressures.
  logic aw_hs, w_hs;
  assign aw_hs = aw_valid & aw_ready;
  assign w_hs  = w_valid & w_ready;

  logic [ADDR_W-1:0] aw_off, aw_chan_full;
  logic              aw_in_win;
  trk_entry_t        aw_entry;

  assign aw_off       = aw_addr - BASE_A;
  assign aw_chan_full = aw_off / STRIDE_A;
  assign aw_in_win    = (aw_addr >= BASE_A) && (aw_chan_full < ADDR_W'(N_CHAN));

  always_comb begin
    aw_entry.len  = aw_len;
    aw_entry.kind = aw_in_win ? decode_kind(aw_addr[3:2]) : KIND_NONE;
    aw_entry.chan = aw_in_win ? aw_chan_full[3:0] : 4'd0;
  end

  logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
  trk_entry_t head;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (AW_DEPTH),
    .dtype        (trk_entry_t)
  ) u_tracker (
    .clk_i   (clk),
    .rst_ni  (~rst_n),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (aw_entry),
    .push_i  (fifo_push),
    .data_o  (head),
    .pop_i   (fifo_pop)
  );

  logic [7:0]        skip_q, skip_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              aw_to_skip, w_to_head, w_skip_dec, last_beat;
  logic              char_valid_q, char_valid_d, err_valid_q, err_valid_d;
  logic              eoc_valid_q, eoc_valid_d;
  logic [7:0]        out_byte_q, out_byte_d;
  logic [31:0]       eoc_code_q, eoc_code_d;
  logic [CHAN_W-1:0] out_chan_q, out_chan_d;
  logic [N_CHAN-1:0] eoc_done_q, eoc_done_d;
  logic              overflow_q, overflow_d, orphan_q, orphan_d;
  logic [7:0]        sel_byte;

  // Once anything was skipped, every later AW is skipped too so W order stays aligned.
  assign aw_to_skip = aw_hs && ((skip_q != 8'd0) || fifo_full);
  assign fifo_push  = aw_hs && !aw_to_skip;
  assign w_to_head  = w_hs && !fifo_empty;
  assign last_beat  = w_last || (beat_cnt_q == head.len);
  assign fifo_pop   = w_to_head && last_beat;
  assign w_skip_dec = w_hs && fifo_empty && (skip_q != 8'd0) && w_last;

  always_comb begin
    sel_byte = 8'd0;
    for (int b = NBYTES - 1; b >= 0; b--) begin
      if (w_strb[b]) sel_byte = w_data[8*b +: 8];
    end
  end

  always_comb begin
    skip_d = skip_q;
    if (w_skip_dec) skip_d = skip_d - 8'd1;
    if (aw_to_skip && (skip_d != 8'hFF)) skip_d = skip_d + 8'd1;

    beat_cnt_d = beat_cnt_q;
    if (w_to_head) beat_cnt_d = last_beat ? 8'd0 : beat_cnt_q + 8'd1;

    overflow_d = overflow_q | aw_to_skip;
    orphan_d   = orphan_q | (w_hs && fifo_empty && (skip_q == 8'd0));
  end

  always_comb begin
    char_valid_d = 1'b0;
    err_valid_d  = 1'b0;
    eoc_valid_d  = 1'b0;
    out_byte_d   = out_byte_q;
    eoc_code_d   = eoc_code_q;
    out_chan_d   = out_chan_q;
    eoc_done_d   = eoc_done_q;
    if (w_to_head) begin
      case (head.kind)
        KIND_STDOUT, KIND_STDERR: begin
          if (|w_strb) begin
            char_valid_d = (head.kind == KIND_STDOUT);
            err_valid_d  = (head.kind == KIND_STDERR);
            out_byte_d   = sel_byte;
            out_chan_d   = head.chan[CHAN_W-1:0];
          end
        end
        KIND_EOC: begin
          // Only the first exit code of a channel is reported.
          for (int c = 0; c < int'(N_CHAN); c++) begin
            if ((head.chan == 4'(c)) && !eoc_done_q[c]) begin
              eoc_valid_d   = 1'b1;
              eoc_code_d    = w_data[31:0];
              out_chan_d    = head.chan[CHAN_W-1:0];
              eoc_done_d[c] = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      skip_q       <= 8'd0;
      beat_cnt_q   <= 8'd0;
      char_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
      eoc_valid_q  <= 1'b0;
      out_byte_q   <= 8'd0;
      eoc_code_q   <= 32'd0;
      out_chan_q   <= '0;
      eoc_done_q   <= '0;
      overflow_q   <= 1'b0;
      orphan_q     <= 1'b0;
    end else begin
      skip_q       <= skip_d;
      beat_cnt_q   <= beat_cnt_d;
      char_valid_q <= char_valid_d;
      err_valid_q  <= err_valid_d;
      eoc_valid_q  <= eoc_valid_d;
      out_byte_q   <= out_byte_d;
      eoc_code_q   <= eoc_code_d;
      out_chan_q   <= out_chan_d;
      eoc_done_q   <= eoc_done_d;
      overflow_q   <= overflow_d;
      orphan_q     <= orphan_d;
    end
  end

  assign char_valid = char_valid_q;
  assign err_valid  = err_valid_q;
  assign eoc_valid  = eoc_valid_q;
  assign out_byte   = out_byte_q;
  assign eoc_code   = eoc_code_q;
  assign out_chan   = out_chan_q;
  assign eoc_done   = eoc_done_q;
  assign all_done   = &eoc_done_q;
  assign overflow   = overflow_q;
  assign orphan_w   = orphan_q;

`ifdef MESH_PRINT_MON_DISPLAY_EN
  always @(posedge clk) begin
    if (!rst_n) begin
      if (char_valid_q) $write("%c", out_byte_q);
      if (err_valid_q)  $display("[ch%0d stderr] %c", out_chan_q, out_byte_q);
      if (eoc_valid_q)  $display("[ch%0d exit] code=%0d", out_chan_q, eoc_code_q);
    end
  end
`endif

endmodule

// File: tb/tb_mesh_print_monitor.sv
// Bench for mesh_print_monitor: directed vector table, overflow/orphan/reset sequences, random vs model.
module tb_mesh_print_monitor;

  localparam int N_CHAN = 4;
  localparam int AW_DEPTH = 8;
  localparam logic [31:0] BASE = 32'h2FFF_0000;
  localparam logic [31:0] STRIDE = 32'h10;

  logic        clk, rst_n;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic [31:0] aw_addr, w_data;
  logic [7:0]  aw_len;
  logic [3:0]  w_strb;
  logic        char_valid, err_valid, eoc_valid, all_done, overflow, orphan_w;
  logic [7:0]  out_byte;
  logic [31:0] eoc_code;
  logic [1:0]  out_chan;
  logic [3:0]  eoc_done;

  mesh_print_monitor #(
    .N_CHAN(N_CHAN), .ADDR_W(32), .DATA_W(32), .AW_DEPTH(AW_DEPTH),
    .MON_BASE(BASE), .CHAN_STRIDE(STRIDE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_data(w_data), .w_strb(w_strb),
    .char_valid(char_valid), .err_valid(err_valid), .eoc_valid(eoc_valid),
    .out_byte(out_byte), .eoc_code(eoc_code), .out_chan(out_chan),
    .eoc_done(eoc_done), .all_done(all_done), .overflow(overflow), .orphan_w(orphan_w)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic awv, input logic awr, input logic [31:0] addr, input logic [7:0] len,
                       input logic wv, input logic wr, input logic [31:0] data, input logic [3:0] strb,
                       input logic last);
    aw_valid = awv; aw_ready = awr; aw_addr = addr; aw_len = len;
    w_valid = wv; w_ready = wr; w_data = data; w_strb = strb; w_last = last;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len);
    drive(1'b1, 1'b1, addr, len, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
    step();
    idle();
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    drive(1'b0, 1'b0, 32'd0, 8'd0, 1'b1, 1'b1, data, strb, last);
    step();
    idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulses"}, {61'd0, char_valid, err_valid, eoc_valid}, 64'd0);
    check({tag, "_out_byte"}, 64'(out_byte), 64'd0);
    check({tag, "_eoc_code"}, 64'(eoc_code), 64'd0);
    check({tag, "_out_chan"}, 64'(out_chan), 64'd0);
    check({tag, "_sticky"}, {58'd0, eoc_done, all_done, overflow, orphan_w}, 64'd0);
  endtask

  // Called at a negedge; leaves rst_n released at a negedge.
  task automatic do_reset(input string tag);
    idle();
    rst_n = 1'b1;
    #1;
    check_all_zero(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        aw_v;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic        w_v;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic [2:0]  e_pulse;   // {char, err, eoc}
    logic [7:0]  e_byte;
    logic [31:0] e_code;
    logic [1:0]  e_chan;
    logic [3:0]  e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v_aw(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] done);
    vec_t v;
    v = '{aw_v: 1'b1, aw_addr: addr, aw_len: len, w_v: 1'b0, w_data: 32'd0, w_strb: 4'd0,
          w_last: 1'b0, e_pulse: 3'b000, e_byte: 8'd0, e_code: 32'd0, e_chan: 2'd0, e_done: done};
    return v;
  endfunction

  function automatic vec_t v_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                               input logic [2:0] pulse, input logic [7:0] b, input logic [31:0] code,
                               input logic [1:0] chan, input logic [3:0] done);
    vec_t v;
    v = '{aw_v: 1'b0, aw_addr: 32'd0, aw_len: 8'd0, w_v: 1'b1, w_data: data, w_strb: strb,
          w_last: last, e_pulse: pulse, e_byte: b, e_code: code, e_chan: chan, e_done: done};
    return v;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int kind; int chan; int len; int cnt; } ment_t;
  ment_t      mq[$];
  int         m_skip;
  bit [3:0]   m_done;
  bit         m_ovf, m_orph;
  logic [37:0] exp_q[$];   // {type(0 err,1 char,2 eoc), chan, value}

  task automatic model_clear();
    mq.delete(); exp_q.delete();
    m_skip = 0; m_done = '0; m_ovf = 0; m_orph = 0;
  endtask

  task automatic model_step(input bit awh, input logic [31:0] addr, input logic [7:0] len,
                            input bit wh, input logic [31:0] data, input logic [3:0] strb, input bit last);
    int size0, skip0;
    ment_t h, e;
    size0 = mq.size();
    skip0 = m_skip;
    if (wh) begin
      if (size0 > 0) begin
        h = mq[0];
        if ((h.kind == 0 || h.kind == 1) && strb != 4'd0) begin
          int lb;
          lb = 0;
          while (strb[lb] == 1'b0) lb++;
          exp_q.push_back({2'(h.kind), 4'(h.chan), 32'((data >> (8 * lb)) & 32'hFF)});
        end else if (h.kind == 2 && !m_done[h.chan]) begin
          m_done[h.chan] = 1'b1;
          exp_q.push_back({2'd2, 4'(h.chan), data});
        end
        h.cnt++;
        if (last || h.cnt == h.len + 1) void'(mq.pop_front());
        else mq[0] = h;
      end else if (skip0 > 0) begin
        if (last) m_skip--;
      end else begin
        m_orph = 1;
      end
    end
    if (awh) begin
      if (addr >= BASE && addr < BASE + N_CHAN * STRIDE) begin
        e.kind = int'((addr >> 2) & 32'd3);
        e.chan = int'((addr - BASE) / STRIDE);
      end else begin
        e.kind = 3;
        e.chan = 0;
      end
      e.len = int'(len);
      e.cnt = 0;
      if (skip0 > 0 || size0 == AW_DEPTH) begin
        m_ovf = 1;
        if (m_skip < 255) m_skip++;
      end else begin
        mq.push_back(e);
      end
    end
  endtask

  task automatic compare_cycle();
    logic [37:0] act, exp;
    logic [1:0]  typ;
    check("pulse_onehot", 64'($countones({char_valid, err_valid, eoc_valid}) <= 1), 64'd1);
    if (char_valid || err_valid || eoc_valid) begin
      typ = eoc_valid ? 2'd2 : (char_valid ? 2'd1 : 2'd0);
      act = {typ, 4'(out_chan), eoc_valid ? eoc_code : 32'(out_byte)};
      if (exp_q.size() == 0) begin
        check("rand_unexpected_pulse", 64'(act), 64'h3F_FFFF_FFFF);
      end else begin
        exp = exp_q.pop_front();
        check("rand_event", 64'(act), 64'(exp));
      end
    end else if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check("rand_missing_pulse", 64'd0, 64'(exp));
    end
    check("rand_eoc_done", 64'(eoc_done), 64'(m_done));
    check("rand_all_done", 64'(all_done), 64'(&m_done));
    check("rand_overflow", 64'(overflow), 64'(m_ovf));
    check("rand_orphan", 64'(orphan_w), 64'(m_orph));
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 7) return BASE + 32'($urandom_range(0, 3)) * STRIDE + 32'($urandom_range(0, 3)) * 4;
    if (sel == 8) return ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : 32'h1000_0000;
    return BASE + N_CHAN * STRIDE + 32'($urandom_range(0, 3)) * 4;
  endfunction

  // ---------------- test ----------------
  initial begin
    idle();
    rst_n = 1'b1;
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b0;

    // Print, exit codes, interleaving with an out-of-window burst, stderr, multi-strobe.
    vecs.push_back(v_aw(32'h2FFF_0014, 8'd0, 4'b0000));
    vecs.push_back(v_w(32'h0000_0041, 4'b0001, 1'b1, 3'b100, 8'h41, 32'd0, 2'd1, 4'b0000));
    vecs.push_back(v_aw(32'h2FFF_0008, 8'd0, 4'b0000));
    vecs.push_back(v_w(32'h0000_0003, 4'b1111, 1'b1, 3'b001, 8'd0, 32'd3, 2'd0, 4'b0001));
    vecs.push_back(v_aw(32'h2FFF_0008, 8'd0, 4'b0001));
    vecs.push_back(v_w(32'h0000_0007, 4'b1111, 1'b1, 3'b000, 8'd0, 32'd0, 2'd0, 4'b0001));
    vecs.push_back(v_aw(32'h2FFF_0018, 8'd0, 4'b0001));
    vecs.push_back(v_w(32'h0000_0000, 4'b1111, 1'b1, 3'b001, 8'd0, 32'd0, 2'd1, 4'b0011));
    vecs.push_back(v_aw(32'h2FFF_0028, 8'd0, 4'b0011));
    vecs.push_back(v_w(32'h0000_0005, 4'b1111, 1'b1, 3'b001, 8'd0, 32'd5, 2'd2, 4'b0111));
    vecs.push_back(v_aw(32'h2FFF_0038, 8'd0, 4'b0111));
    vecs.push_back(v_w(32'hDEAD_0009, 4'b1111, 1'b1, 3'b001, 8'd0, 32'hDEAD_0009, 2'd3, 4'b1111));
    vecs.push_back(v_aw(32'h1000_0000, 8'd3, 4'b1111));
    vecs.push_back(v_aw(32'h2FFF_0024, 8'd0, 4'b1111));
    vecs.push_back(v_w(32'h0000_0055, 4'b0001, 1'b0, 3'b000, 8'd0, 32'd0, 2'd0, 4'b1111));
    vecs.push_back(v_w(32'h0000_0055, 4'b0001, 1'b0, 3'b000, 8'd0, 32'd0, 2'd0, 4'b1111));
    vecs.push_back(v_w(32'h0000_0055, 4'b0001, 1'b0, 3'b000, 8'd0, 32'd0, 2'd0, 4'b1111));
    vecs.push_back(v_w(32'h0000_0055, 4'b0001, 1'b1, 3'b000, 8'd0, 32'd0, 2'd0, 4'b1111));
    vecs.push_back(v_w(32'h0000_4200, 4'b0010, 1'b1, 3'b100, 8'h42, 32'd0, 2'd2, 4'b1111));
    vecs.push_back(v_aw(32'h2FFF_0030, 8'd1, 4'b1111));
    vecs.push_back(v_w(32'h4300_0000, 4'b1000, 1'b0, 3'b010, 8'h43, 32'd0, 2'd3, 4'b1111));
    vecs.push_back(v_w(32'h0000_0044, 4'b0000, 1'b1, 3'b000, 8'd0, 32'd0, 2'd0, 4'b1111));
    vecs.push_back(v_aw(32'h2FFF_0004, 8'd0, 4'b1111));
    vecs.push_back(v_w(32'h0000_6162, 4'b0011, 1'b1, 3'b100, 8'h62, 32'd0, 2'd0, 4'b1111));

    foreach (vecs[i]) begin
      drive(vecs[i].aw_v, vecs[i].aw_v, vecs[i].aw_addr, vecs[i].aw_len,
            vecs[i].w_v, vecs[i].w_v, vecs[i].w_data, vecs[i].w_strb, vecs[i].w_last);
      step();
      idle();
      check($sformatf("vec%0d_pulses", i), 64'({char_valid, err_valid, eoc_valid}), 64'(vecs[i].e_pulse));
      if (vecs[i].e_pulse[2] || vecs[i].e_pulse[1]) begin
        check($sformatf("vec%0d_byte", i), 64'(out_byte), 64'(vecs[i].e_byte));
        check($sformatf("vec%0d_chan", i), 64'(out_chan), 64'(vecs[i].e_chan));
      end
      if (vecs[i].e_pulse[0]) begin
        check($sformatf("vec%0d_code", i), 64'(eoc_code), 64'(vecs[i].e_code));
        check($sformatf("vec%0d_chan", i), 64'(out_chan), 64'(vecs[i].e_chan));
      end
      check($sformatf("vec%0d_done", i), 64'(eoc_done), 64'(vecs[i].e_done));
      check($sformatf("vec%0d_all_done", i), 64'(all_done), 64'(&vecs[i].e_done));
    end
    check("table_overflow", 64'(overflow), 64'd0);
    check("table_orphan", 64'(orphan_w), 64'd0);

    // Overflow: nine AWs into an eight-deep tracker, then nine single-beat writes.
    do_reset("ovf_reset");
    for (int i = 0; i < 9; i++) begin
      send_aw(32'h2FFF_0004, 8'd0);
      check($sformatf("ovf_after_aw%0d", i + 1), 64'(overflow), (i == 8) ? 64'd1 : 64'd0);
    end
    for (int i = 0; i < 9; i++) begin
      send_w(32'h30 + 32'(i), 4'b0001, 1'b1);
      check($sformatf("ovf_w%0d_char", i + 1), 64'(char_valid), (i < 8) ? 64'd1 : 64'd0);
      if (i < 8) check($sformatf("ovf_w%0d_byte", i + 1), 64'(out_byte), 64'h30 + 64'(i));
      check($sformatf("ovf_w%0d_orphan", i + 1), 64'(orphan_w), 64'd0);
    end
    send_w(32'h0000_0077, 4'b0001, 1'b1);
    check("ovf_drained_orphan", 64'(orphan_w), 64'd1);
    check("ovf_drained_nochar", 64'(char_valid), 64'd0);

    // Orphan W, then reset in the middle of a tracked burst.
    do_reset("orph_reset");
    send_w(32'h0000_0041, 4'b0001, 1'b1);
    check("orphan_set", 64'(orphan_w), 64'd1);
    check("orphan_no_pulse", 64'({char_valid, err_valid, eoc_valid}), 64'd0);
    send_aw(32'h2FFF_0004, 8'd3);
    send_w(32'h0000_0058, 4'b0001, 1'b0);
    check("midburst_char", 64'(char_valid), 64'd1);
    do_reset("midburst_reset");
    send_w(32'h0000_0059, 4'b0001, 1'b0);
    check("post_reset_orphan", 64'(orphan_w), 64'd1);
    check("post_reset_no_char", 64'(char_valid), 64'd0);

    // Randomized traffic against the model, with a reset in the middle.
    do_reset("rand_reset0");
    model_clear();
    for (int cyc = 0; cyc < 1200; cyc++) begin
      logic awv, awr, wv, wr, wl;
      logic [31:0] addr, data;
      logic [7:0]  len;
      logic [3:0]  strb;
      if (cyc == 600) begin
        do_reset("rand_reset1");
        model_clear();
      end
      awv  = ($urandom_range(0, 99) < ((cyc % 300) < 120 ? 70 : 25));
      awr  = ($urandom_range(0, 99) < 85);
      wv   = ($urandom_range(0, 99) < 50);
      wr   = ($urandom_range(0, 99) < 85);
      wl   = ($urandom_range(0, 99) < 35);
      addr = rand_addr();
      len  = 8'($urandom_range(0, 3));
      data = $urandom();
      strb = 4'($urandom_range(0, 15));
      drive(awv, awr, addr, len, wv, wr, data, strb, wl);
      step();
      model_step(awv & awr, addr, len, wv & wr, data, strb, wl);
      compare_cycle();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
